// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALUControl codes (shared with the ALU), ALUOp and FSM state encodings.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp request plus the instruction funct field to an ALUControl code.
module alu_decoder
    import mips_defs::*;
(
    input  aluop_e      ALUOp,
    input  logic [5:0]  Funct,
    output logic [2:0]  ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        unique case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct codes fall back to add rather than flagging an error.
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath; sequences fetch/decode/execute
// around the shared ALU and stalls on the memory ready handshake.
module multicycle_control_unit
    import mips_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       ZeroFlag,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IllegalOp
);

    state_e state_q, state_d;
    aluop_e alu_op;
    logic   pc_write;
    logic   branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (MemReady) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_B;
        PCSrc     = PCSRC_ALURES;
        IllegalOp = 1'b0;
        alu_op    = ALUOP_ADD;
        pc_write  = 1'b0;
        branch    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                // Reset also holds the state in FETCH; keep the IR and PC frozen then.
                IRWrite  = MemReady & rst_n;
                pc_write = MemReady & rst_n;
            end
            S_DECODE: begin
                ALUSrcB   = SRCB_IMMSH;
                IllegalOp = ~op_supported(Op);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCEn = pc_write | (branch & ZeroFlag);

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .Funct      (Funct),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each driven cycle pushes the expected control word derived
// from per-instruction step lists; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op, Funct;
    logic       ZeroFlag, MemReady;
    logic       MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       PCEn, IllegalOp;

    typedef struct packed {
        logic       mr, mw, iord, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [1:0] pcsrc;
        logic       pcen, ill;
    } ctl_t;

    typedef struct {
        ctl_t  c;
        string nm;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    ctl_t act;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .ZeroFlag(ZeroFlag),
        .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .PCEn(PCEn), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    assign act = '{mr: MemRead, mw: MemWrite, iord: IorD, irw: IRWrite, rdst: RegDst,
                   m2r: MemtoReg, rw: RegWrite, srca: ALUSrcA, srcb: ALUSrcB,
                   aluc: ALUControl, pcsrc: PCSrc, pcen: PCEn, ill: IllegalOp};

    always @(negedge clk) begin
        exp_t x;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            checks++;
            if (act !== x.c) begin
                errors++;
                $display("FAIL %s got=%h want=%h @%0t", x.nm, act, x.c, $time);
            end
        end
    end

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.aluc = 3'b010;
        return c;
    endfunction

    function automatic ctl_t fetch_word(input logic done);
        ctl_t c = idle();
        c.mr = 1'b1; c.srcb = 2'b01; c.irw = done; c.pcen = done;
        return c;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // One clock of stimulus: drive inputs, queue expectation, advance.
    task automatic cyc(input ctl_t e, input string nm, input logic mrdy, input logic zf);
        MemReady = mrdy;
        ZeroFlag = zf;
        sbq.push_back('{c: e, nm: nm});
        @(posedge clk); #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fetch_phase(input int wf);
        for (int i = 0; i < wf; i++) cyc(fetch_word(1'b0), "fetch_wait", 1'b0, rb());
        cyc(fetch_word(1'b1), "fetch", 1'b1, rb());
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                             input int wf, input int wm);
        ctl_t e;
        logic legal;
        Op = op; Funct = fn;
        legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
        fetch_phase(wf);
        e = idle(); e.srcb = 2'b11; e.ill = !legal;
        cyc(e, "decode", rb(), rb());
        if (!legal) return;
        case (op)
            6'b100011, 6'b101011: begin
                e = idle(); e.srca = 1'b1; e.srcb = 2'b10;
                cyc(e, "memadr", rb(), rb());
                e = idle(); e.iord = 1'b1;
                if (op == 6'b100011) e.mr = 1'b1; else e.mw = 1'b1;
                for (int i = 0; i < wm; i++) cyc(e, "mem_wait", 1'b0, rb());
                cyc(e, "mem_done", 1'b1, rb());
                if (op == 6'b100011) begin
                    e = idle(); e.m2r = 1'b1; e.rw = 1'b1;
                    cyc(e, "memwb", rb(), rb());
                end
            end
            6'b000000: begin
                e = idle(); e.srca = 1'b1; e.srcb = 2'b00; e.aluc = ref_alu(fn);
                cyc(e, "execute", rb(), rb());
                e = idle(); e.rdst = 1'b1; e.rw = 1'b1;
                cyc(e, "aluwb", rb(), rb());
            end
            6'b000100: begin
                e = idle(); e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcen = zf;
                cyc(e, "branch", rb(), zf);
            end
            6'b001000: begin
                e = idle(); e.srca = 1'b1; e.srcb = 2'b10;
                cyc(e, "addiexec", rb(), rb());
                e = idle(); e.rw = 1'b1;
                cyc(e, "addiwb", rb(), rb());
            end
            default: begin
                e = idle(); e.pcsrc = 2'b10; e.pcen = 1'b1;
                cyc(e, "jump", rb(), rb());
            end
        endcase
    endtask

    logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                           6'b001000, 6'b000010, 6'b111111};
    logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        ctl_t e;
        logic [5:0] op, fn;
        rst_n = 1'b0; Op = '0; Funct = '0; ZeroFlag = 1'b0; MemReady = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cyc(fetch_word(1'b0), "in_reset", 1'b1, rb());
        rst_n = 1'b1;
        cyc(fetch_word(1'b1), "release_fetch", 1'b1, rb());
        // Finish that first fetched instruction as a jump to stay aligned.
        Op = 6'b000010;
        e = idle(); e.srcb = 2'b11;
        cyc(e, "decode0", 1'b1, rb());
        e = idle(); e.pcsrc = 2'b10; e.pcen = 1'b1;
        cyc(e, "jump0", 1'b1, rb());

        run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 3);
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b100010, 1'b0, 1, 0);
        run_instr(6'b000000, 6'b011111, 1'b0, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b001000, 6'b000000, 1'b0, 2, 0);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);

        // Abort a load in MEMRD with an asynchronous reset.
        Op = 6'b100011; Funct = '0;
        fetch_phase(0);
        e = idle(); e.srcb = 2'b11; cyc(e, "abort_decode", 1'b1, rb());
        e = idle(); e.srca = 1'b1; e.srcb = 2'b10; cyc(e, "abort_memadr", 1'b1, rb());
        e = idle(); e.mr = 1'b1; e.iord = 1'b1; cyc(e, "abort_memrd", 1'b0, rb());
        MemReady = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (act !== fetch_word(1'b0)) begin
            errors++;
            $display("FAIL async_abort got=%h want=%h", act, fetch_word(1'b0));
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) cyc(fetch_word(1'b0), "abort_hold", 1'b1, rb());
        rst_n = 1'b1;
        run_instr(6'b000000, 6'b100101, 1'b0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk); #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style control FSM that sequences a multicycle MIPS datapath around the shared ArithmeticLogicUnit. It decodes the instruction register's opcode/funct and drives the ALUControl code, SrcA/SrcB mux selects, register-file/memory/IR/PC write strobes and the PC source select. It consumes the ALU's ZeroFlag for branch resolution. It is the producer side of the ALUControl/ZeroFlag interface and stalls on a memory ready handshake.

## Interface
- No parameters; opcode, funct and ALUControl encodings are fixed constants (see Structure).
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset; state forced to FETCH immediately on assertion, released synchronously on the next rising edge after deassertion
- Op  in  6  instruction[31:26] from the IR
- Funct  in  6  instruction[5:0] from the IR
- ZeroFlag  in  1  ALU zero output; sampled only in BRANCH
- MemReady  in  1  memory has completed the current access this cycle
- MemRead, MemWrite  out  1  memory access request, held until MemReady
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemtoReg  out  1  write data: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC write enable = PCWrite | (Branch & ZeroFlag)
- IllegalOp  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP. 4-bit encoding.
- FETCH has MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU add, and PCSrc=00. IRWrite and PCWrite are asserted only in the cycle where MemReady=1; FETCH then moves to DECODE. Otherwise it holds in FETCH.
- DECODE has ALUSrcA=0, ALUSrcB=11, ALU add (branch target precompute). Next state by Op:
  - lw 100011 or sw 101011 -> MEMADR
  - 000000 -> EXECUTE
  - beq 000100 -> BRANCH
  - addi 001000 -> ADDIEXEC
  - j 000010 -> JUMP
  - any other Op -> FETCH with IllegalOp=1 (instruction treated as NOP)
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady, then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other Funct -> 010 (add)
  - Next state: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1, so PCEn=ZeroFlag. Then FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add, then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- JUMP: PCSrc=10, PCWrite=1, then FETCH.
- All outputs not listed for a state are 0; ALUControl defaults to 010.
- Outputs are a pure function of state plus the inputs named above: MemReady in FETCH, Op in DECODE, Funct in EXECUTE, ZeroFlag in BRANCH.

## Timing
- During reset, state=FETCH. MemRead=1, IorD=0, ALUSrcB=01, ALUControl=010, and all other outputs 0. IRWrite and PCEn are forced to 0 while rst_n=0, regardless of MemReady.
- Cycle counts with zero-wait memory (MemReady tied 1):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3
  - illegal opcode 2
- Each wait cycle (MemReady=0) adds one cycle to FETCH, MEMRD or MEMWR.
- Memory handshake: the request stays stable while waiting, and the access completes in the cycle MemReady=1. MemReady in any other state is ignored.
- ZeroFlag is combinational within the BRANCH cycle; no registering.
- rst_n asserted mid-instruction aborts it immediately. No RegWrite or MemWrite is issued after assertion.

## Structure
- Shared package/header `mips_defs` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALUControl codes (ALU_ADD=3'b010, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), also used by ArithmeticLogicUnit
  - state encodings
- One sub-module: `alu_decoder` (combinational ALUOp[1:0] + Funct -> ALUControl). The FSM drives ALUOp: 00 add, 01 sub, 10 funct.

## Test plan
- Reset held with MemReady=1: state FETCH, IRWrite=0, PCEn=0. After release, the first edge asserts IRWrite=1 and PCEn=1.
- lw (Op=100011), MemReady=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 with MemtoReg=1 in cycle 5.
- sw with MemReady low for 3 cycles in MEMWR: MemWrite=1, IorD=1 held 4 cycles. Then FETCH.
- R-type Funct=101010: ALUControl=111 in EXECUTE, RegDst=1 and RegWrite=1 in ALUWB. Repeat for 100010 -> 110.
- beq: in BRANCH, ALUControl=110 and PCSrc=01. With ZeroFlag=1, PCEn=1; with ZeroFlag=0, PCEn=0.
- Op=111111: IllegalOp=1 for one cycle in DECODE, then FETCH, with no RegWrite or MemWrite. Also assert rst_n=0 during MEMRD: state becomes FETCH immediately and no RegWrite occurs.
